// File: rtl/vldrdy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vldrdy_pkg
// Description : Shared types, limits and helpers for the valid/ready fabric
//               fork controller.
//               - state_e      : EMPTY / HOLD state of the one-entry holding
//                                register.
//               - VLDRDY_MAX_OUT: widest fork supported.
//               - onehot_all() : completion term, every branch either served
//                                earlier or taking this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package vldrdy_pkg;

  localparam int VLDRDY_MAX_OUT = 8;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Both vectors are VLDRDY_MAX_OUT wide. Callers pad the unused upper bits
  // with ones so that they never hold completion back.
  function automatic logic onehot_all(
    input logic [VLDRDY_MAX_OUT-1:0] served,
    input logic [VLDRDY_MAX_OUT-1:0] take
  );
    return &(served | take);
  endfunction

endpackage : vldrdy_pkg
`default_nettype wire

// File: rtl/vldrdy_fork_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vldrdy_fork_ctrl
// Description : Registered eager fork. One upstream beat is captured into a
//               one-entry holding register and broadcast to N_OUT consumers,
//               each of which may accept in a different cycle. Per-branch
//               served bits remember who has already taken the beat.
//
// Parameters  : N_OUT  - number of downstream branches (2..8)
//               DATA_W - payload width
//
// Ports       : i_clk    in   clock
//               i_rst    in   synchronous active-high reset
//               i_valid  in   upstream beat valid
//               i_ready  out  upstream may transfer this cycle
//               i_data   in   upstream payload
//               i_mask   in   branch-enable mask (VLDRDY_FORK_MASK_EN only)
//               o_valid  out  per-branch valid, bit k = branch k
//               o_ready  in   per-branch ready
//               o_data   out  payload broadcast to all branches
//
// Options     : `define VLDRDY_FORK_MASK_EN adds i_mask. Masked-off branches
//               are marked served on load, so they never see the beat. When
//               the macro is undefined every beat goes to every branch.
//
// Revision    : 1.0 - initial release
// ============================================================================
module vldrdy_fork_ctrl
  import vldrdy_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
`ifdef VLDRDY_FORK_MASK_EN
  input  logic [N_OUT-1:0]  i_mask,
`endif
  output logic [N_OUT-1:0]  o_valid,
  input  logic [N_OUT-1:0]  o_ready,
  output logic [DATA_W-1:0] o_data
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter check
  // --------------------------------------------------------------------------
  generate
    if ((N_OUT < 2) || (N_OUT > VLDRDY_MAX_OUT)) begin : g_param_check
      $error("vldrdy_fork_ctrl: N_OUT must be in 2..%0d", VLDRDY_MAX_OUT);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [N_OUT-1:0]    served_q, served_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                full;
  logic [N_OUT-1:0]    take;
  logic                done;
  logic [N_OUT-1:0]    load_served;
  logic [VLDRDY_MAX_OUT-1:0] served_pad;
  logic [VLDRDY_MAX_OUT-1:0] take_pad;

  // A freshly loaded beat starts with the disabled branches already served.
`ifdef VLDRDY_FORK_MASK_EN
  assign load_served = ~i_mask;
`else
  assign load_served = '0;
`endif

  assign full = (state_q == ST_HOLD);

  // o_valid depends only on registered state, so there is no combinational
  // path from i_valid to any output.
  assign o_valid = {N_OUT{full}} & ~served_q;
  assign o_data  = data_q;
  assign take    = o_valid & o_ready;

  // Pad to the package width with ones so absent branches count as served.
  always_comb begin
    served_pad              = '1;
    take_pad                = '1;
    served_pad[N_OUT-1:0]   = served_q;
    take_pad[N_OUT-1:0]     = take;
  end

  assign done    = full & onehot_all(served_pad, take_pad);

  // Ready to upstream follows o_ready combinationally: the register frees up
  // in the same cycle the last outstanding branch takes its copy.
  assign i_ready = ~full | done;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    data_d   = data_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (i_valid) begin
          state_d  = ST_HOLD;
          data_d   = i_data;
          served_d = load_served;
        end
      end

      ST_HOLD: begin
        if (done) begin
          if (i_valid) begin
            // Back-to-back: the outgoing beat completes and the next one is
            // captured on the same edge.
            data_d   = i_data;
            served_d = load_served;
          end else begin
            state_d  = ST_EMPTY;
            served_d = '0;
          end
        end else begin
          served_d = served_q | take;
        end
      end

      default: begin
        state_d  = ST_EMPTY;
        served_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_EMPTY;
      served_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
      data_q   <= data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol properties
  // --------------------------------------------------------------------------
  // While a beat is still owed to some branch its payload must not move.
  a_data_stable : assert property (
    @(posedge i_clk) disable iff (i_rst)
      (full && !done) |=> $stable(data_q)
  ) else $error("vldrdy_fork_ctrl: payload changed while beat outstanding");

  // Served bits carry no meaning in EMPTY and are kept cleared there.
  a_served_clear : assert property (
    @(posedge i_clk) disable iff (i_rst)
      !full |-> (served_q == '0)
  ) else $error("vldrdy_fork_ctrl: served bits set while empty");

endmodule : vldrdy_fork_ctrl
`default_nettype wire

// File: tb/tb_vldrdy_fork_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vldrdy_fork_ctrl
// Description : Self-checking bench for vldrdy_fork_ctrl. The reference model
//               counts accepted beats and, per branch, how many beats that
//               branch has received; outputs are derived from those counts.
//               Directed scenarios come first, then a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vldrdy_fork_ctrl;

  localparam int N      = 2;
  localparam int DW     = 32;
  localparam int N_RAND = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [N-1:0]  in_mask;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: beats accepted so far, beats delivered per branch,
  // and the payload of the most recently accepted beat.
  int            acc;
  int            got [N];
  logic [DW-1:0] last_data;

  always #5 clk = ~clk;

  vldrdy_fork_ctrl #(
    .N_OUT  (N),
    .DATA_W (DW)
  ) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .i_ready (in_ready),
    .i_data  (in_data),
`ifdef VLDRDY_FORK_MASK_EN
    .i_mask  (in_mask),
`endif
    .o_valid (out_valid),
    .o_ready (out_ready),
    .o_data  (out_data)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    acc       = 0;
    last_data = '0;
    for (int k = 0; k < N; k++) got[k] = 0;
  endtask

  // Pulse reset for one edge, inputs idle.
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '1;
    out_ready = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs just after the edge, compare mid-cycle, then
  // advance the model by what the handshakes imply.
  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic [N-1:0] rdy, input logic [N-1:0] msk);
    logic [N-1:0] e_valid;
    logic         e_ready;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
`ifdef VLDRDY_FORK_MASK_EN
    in_mask   = msk;
`else
    in_mask   = '1;
`endif
    e_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      e_valid[k] = (got[k] < acc);
      // A branch still owed the beat must take it now for upstream to move.
      if (e_valid[k] && !rdy[k]) e_ready = 1'b0;
    end
    #4;
    chk("o_valid", 64'(out_valid), 64'(e_valid));
    chk("i_ready", 64'(in_ready), 64'(e_ready));
    chk("o_data", 64'(out_data), 64'(last_data));
    for (int k = 0; k < N; k++)
      if (e_valid[k] && rdy[k]) got[k]++;
    if (v && e_ready) begin
      acc++;
      last_data = d;
      for (int k = 0; k < N; k++)
        if (!in_mask[k]) got[k] = acc;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '1;
    out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state, then single beat with both branches ready.
    step(1'b1, 32'hA5A5_0001, 2'b11, 2'b11);
    chk("t1_valid_after_accept", 64'(out_valid), 64'(2'b11));
    step(1'b0, 32'h0, 2'b11, 2'b11);
    step(1'b0, 32'h0, 2'b11, 2'b11);
    chk("t1_valid_cleared", 64'(out_valid), 64'(2'b00));

    // Staggered acceptance.
    step(1'b1, 32'h0000_1234, 2'b00, 2'b11);
    step(1'b0, 32'h0, 2'b01, 2'b11);
    step(1'b0, 32'h0, 2'b10, 2'b11);
    step(1'b0, 32'h0, 2'b00, 2'b11);

    // Streaming at one beat per cycle.
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 2'b11, 2'b11);
    step(1'b0, 32'h0, 2'b11, 2'b11);

    // Stall on branch 1 while branch 0 is ready every cycle.
    step(1'b1, 32'h0000_0055, 2'b01, 2'b11);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hDEAD_0000 + DW'(i), 2'b01, 2'b11);
    step(1'b0, 32'h0, 2'b10, 2'b11);
    step(1'b0, 32'h0, 2'b11, 2'b11);

    // Reset while branch 0 is served and branch 1 is still owed.
    step(1'b1, 32'h0000_0099, 2'b01, 2'b11);
    step(1'b0, 32'h0, 2'b01, 2'b11);
    do_reset();
    chk("t5_valid_after_rst", 64'(out_valid), 64'(2'b00));
    chk("t5_ready_after_rst", 64'(in_ready), 64'(1'b1));
    chk("t5_data_after_rst", 64'(out_data), 64'(0));
    step(1'b0, 32'h0, 2'b11, 2'b11);

`ifdef VLDRDY_FORK_MASK_EN
    // Masked delivery, then an all-zero mask that drops straight through.
    step(1'b1, 32'h0000_0077, 2'b00, 2'b10);
    chk("t6_only_branch1", 64'(out_valid), 64'(2'b10));
    step(1'b0, 32'h0, 2'b11, 2'b11);
    step(1'b1, 32'h0000_0088, 2'b00, 2'b00);
    chk("t6_zero_mask_silent", 64'(out_valid), 64'(2'b00));
    step(1'b1, 32'h0000_0089, 2'b00, 2'b11);
    chk("t6_next_beat_out", 64'(out_valid), 64'(2'b11));
    step(1'b0, 32'h0, 2'b11, 2'b11);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 7),
             DW'($urandom()),
             N'($urandom()),
             N'($urandom()));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_vldrdy_fork_ctrl
`default_nettype wire

// File: doc/vldrdy_fork_ctrl.md
Name: vldrdy_fork_ctrl

Overview:
- Registered eager fork controller for the valid/ready fabric.
- Accepts one beat from a single upstream producer into a one-entry holding register and broadcasts it to N_OUT consumers.
- Each consumer may accept in a different cycle. Per-branch "served" bits track which consumers have taken the beat.
- Replaces the lazy combinational fork on paths where consumers' ready signals are uncorrelated or would create combinational loops.

Parameters:
N_OUT, 2, number of downstream branches (2..8)
DATA_W, 32, payload width in bits

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  upstream beat valid
i_ready  output  1  upstream may transfer this cycle
i_data  input  DATA_W  upstream payload
o_valid  output  N_OUT  per-branch valid, bit k = branch k
o_ready  input  N_OUT  per-branch ready
o_data  output  DATA_W  payload broadcast to all branches

Behaviour:
- Clocking and reset:
  - One clock, i_clk.
  - Reset i_rst is synchronous and active-high.
  - While i_rst is high at a clock edge: full=0, served=0, data register=0.
  - Consequently o_valid=0, o_data=0 and i_ready=1 from the first cycle after reset.
  - Reset mid-operation discards the held beat; no branch sees it again.
- State:
  - Two states, EMPTY (full=0) and HOLD (full=1).
  - served[N_OUT-1:0] is meaningful only in HOLD.
- Outputs:
  - o_valid[k] = full & ~served[k]. Once raised, it stays high until branch k handshakes.
  - o_data = data register, held stable for the whole HOLD period.
- Branch handshake: take[k] = o_valid[k] & o_ready[k].
- Completion: done = full & &(served | take).
  - done is true when every branch has been served, either earlier or in this cycle.
- Upstream handshake:
  - i_ready = ~full | done. This is combinational from o_ready.
  - No combinational path from i_valid to any output.
- Transitions:
  - EMPTY, i_valid=1 → HOLD; load i_data; served=0.
  - EMPTY, i_valid=0 → stay EMPTY.
  - HOLD, ~done → served |= take.
  - HOLD, done, i_valid=1 → stay HOLD; load new i_data; served=0. This is back-to-back operation.
  - HOLD, done, i_valid=0 → EMPTY; served=0.
- Throughput and latency:
  - Latency from upstream accept to o_valid is 1 cycle.
  - Peak throughput is 1 beat/cycle when all o_ready are held high.
- Simultaneous events:
  - All branches taking in the same cycle is a legal completion.
  - A branch taking in the same cycle as the last other branch also completes.
- Branch isolation:
  - A branch never sees two valid cycles for the same beat after its handshake.
  - A slow branch stalls upstream but never blocks delivery to the other branches.
- Assertions: o_data stable while any o_valid bit is high and unserved; served never has a bit set while full=0.

Optional Feature:
- Macro: VLDRDY_FORK_MASK_EN.
- When defined:
  - Adds port i_mask input N_OUT: branch-enable mask, sampled together with i_data on upstream accept.
  - Masked-off branches load served[k]=1, so their o_valid stays 0.
  - A beat with i_mask all zero completes in the same cycle it would be presented: it enters HOLD with done=1 and is dropped the next cycle.
- When undefined: no i_mask port; behaviour is identical to i_mask all ones.

Decomposition:
- Shared package vldrdy_pkg holds:
  - state enum {ST_EMPTY, ST_HOLD};
  - localparam VLDRDY_MAX_OUT=8;
  - function onehot_all(served, take) returning the done term.
- No sub-module is required. Served tracking and the data register live in one module.
- A parameter-check generate block errors out if N_OUT is outside 2..8.

Test Plan:
1. Reset, then i_valid=1, i_data=0xA5A5_0001, o_ready=2'b11 → i_ready=1; next cycle o_valid=2'b11, o_data=0xA5A5_0001; the following cycle o_valid=0.
2. Staggered: beat 0x1234 with o_ready=2'b01, then 2'b10 a cycle later → o_valid goes 11→10→00; i_ready is 0 until branch 1 takes, then 1 in the same cycle.
3. Streaming: i_valid=1 continuously with data 1,2,3,4, o_ready=11 → one beat per cycle, o_data 1,2,3,4 on consecutive cycles, i_ready stays 1.
4. Stall: o_ready=2'b01 held for 5 cycles with beat 0x55 → branch 0 gets exactly one valid cycle; o_valid[1] stays high; o_data=0x55 throughout; i_ready=0 for 5 cycles.
5. Reset mid-HOLD: served=2'b01, i_rst pulsed → next cycle o_valid=0, i_ready=1, o_data=0.
6. VLDRDY_FORK_MASK_EN: i_mask=2'b10 with beat 0x77 → only o_valid[1] rises. i_mask=2'b00 → no o_valid, and the next beat is accepted after 1 cycle.
